// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one Booth step per cycle, start/done handshake.
// Optional MUL_EARLY_OUT_EN retires the remaining no-op steps with one barrel shift.
module booth_seq_multiplier #(
    parameter int unsigned WIDTH = 33,
    localparam int unsigned PW = 2 * WIDTH - 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [PW-1:0]    o_c,
    output logic             o_done,
    output logic             o_busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned VW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    c_q, c_d;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;
    logic [VW-1:0]    step_vec;

    assign m_ext = {m_q[WIDTH-1], m_q};

    always_comb begin
        sum = acc_q;
        case ({q_q[0], q1_q})
            2'b10:   sum = acc_q - m_ext;
            2'b01:   sum = acc_q + m_ext;
            default: sum = acc_q;
        endcase
        // {A,Q,q_1} shifted right arithmetically after the add/subtract
        step_vec = {sum[WIDTH], sum, q_q};
    end

`ifdef MUL_EARLY_OUT_EN
    logic [WIDTH-1:0] rem_mask;
    logic             early_hit;
    logic signed [VW-1:0] cur_vec;
    logic [VW-1:0]    early_vec;

    always_comb begin
        rem_mask  = ~({WIDTH{1'b1}} << cnt_q);
        // Unscanned multiplier bits plus q_1 all equal: every remaining pair is 00 or 11
        early_hit = (((q_q & rem_mask) == '0) && !q1_q) ||
                    (((q_q & rem_mask) == rem_mask) && q1_q);
        cur_vec   = {acc_q, q_q, q1_q};
        early_vec = cur_vec >>> cnt_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        c_d     = c_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (i_start) begin
                    m_d     = i_a;
                    acc_d   = '0;
                    q_d     = i_b;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = StBusy;
                end
            end
            StBusy: begin
`ifdef MUL_EARLY_OUT_EN
                if (early_hit) begin
                    {acc_d, q_d, q1_d} = early_vec;
                    cnt_d   = '0;
                    c_d     = early_vec[PW:1];
                    state_d = StDone;
                end else begin
`else
                begin
`endif
                    {acc_d, q_d, q1_d} = step_vec;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        c_d     = step_vec[PW:1];
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
        end
    end

    assign o_c    = c_q;
    assign o_done = (state_q == StDone);
    assign o_busy = (state_q == StBusy);

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: vector table, corner sequences, random vs model.
module tb_booth_seq_multiplier;

    localparam int unsigned WIDTH = 33;
    localparam int unsigned PW    = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic [PW-1:0]    c;
    logic             done, busy;

    int passed = 0;
    int total  = 0;

    booth_seq_multiplier #(.WIDTH(WIDTH)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_a    (a),
        .i_b    (b),
        .o_c    (c),
        .o_done (done),
        .o_busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [PW-1:0]    c;
    } vec_t;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: exact signed product, low PW bits
    function automatic logic [PW-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic signed [2*WIDTH-1:0] px, py, pr;
        px = $signed(x);
        py = $signed(y);
        pr = px * py;
        return pr[PW-1:0];
    endfunction

    function automatic logic lat_ok(input int lat);
`ifdef MUL_EARLY_OUT_EN
        return (lat >= 2) && (lat <= WIDTH + 1);
`else
        return lat == WIDTH + 1;
`endif
    endfunction

    // Start at a negedge (cycle 0); returns cycle index of o_done (0 on timeout)
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          output logic [PW-1:0] res, output int lat, output int busy_cnt);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'({$urandom, $urandom});
        b = WIDTH'({$urandom, $urandom});
        lat = 0; busy_cnt = 0; res = '0;
        for (int n = 1; n <= 200; n++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = n;
                res = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t vecs[10];
    logic [PW-1:0] res, exp_c;
    int lat, bc, seen;

    initial begin
        vecs[0] = '{33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[1] = '{33'h1_FFFFFFFF, 33'h0_00000002, 64'hFFFFFFFF_FFFFFFFE};
        vecs[2] = '{33'h1_80000000, 33'h1_80000000, 64'h40000000_00000000};
        vecs[3] = '{33'h0_00000003, 33'h0_00000005, 64'd15};
        vecs[4] = '{33'h0_12345678, 33'h0_00000003, 64'h00000000_369D0368};
        vecs[5] = '{33'h1_00000000, 33'h0_00000001, 64'hFFFFFFFF_00000000};
        vecs[6] = '{33'h0_FFFFFFFF, 33'h1_00000000, 64'h00000001_00000000};
        vecs[7] = '{33'h1_FFFFFFFF, 33'h1_FFFFFFFF, 64'd1};
        vecs[8] = '{33'h0_00000000, 33'h1_23456789, 64'd0};
        vecs[9] = '{33'h1_00000000, 33'h1_00000000, 64'h00000000_00000000};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        check("reset_c", c, '0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, res, lat, bc);
            check($sformatf("vec%0d_c", i), res, vecs[i].c);
            check($sformatf("vec%0d_lat", i), 64'(lat_ok(lat)), 64'd1);
`ifndef MUL_EARLY_OUT_EN
            if (i == 1) check("vec1_busy_cycles", 64'(bc), 64'(WIDTH));
`else
            if (i == 4) check("early_out_faster", 64'(lat < WIDTH + 1), 64'd1);
`endif
        end

        // Done is a single-cycle pulse and the product holds afterwards
        @(negedge clk);
        check("done_pulse_low", 64'(done), 64'd0);
        check("c_holds", c, 64'd0);

        // Start while busy is ignored; back-to-back start accepted from DONE
        @(negedge clk);
        a = 33'd3; b = 33'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; seen = 0;
        for (int n = 1; n <= 200; n++) begin
            if (n == 10) begin a = 33'd7; b = 33'd7; start = 1'b1; end
            if (n == 11) start = 1'b0;
            if (done) begin lat = n; break; end
            @(negedge clk);
        end
        check("busy_start_c", c, 64'd15);
        check("busy_start_lat", 64'(lat_ok(lat)), 64'd1);
        a = 33'd7; b = 33'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            if (done) begin lat = n; break; end
            @(negedge clk);
        end
        check("b2b_c", c, 64'd49);
        check("b2b_lat", 64'(lat_ok(lat)), 64'd1);

        // Async reset mid-operation aborts without a done pulse
        @(negedge clk);
        a = 33'd9; b = 33'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n < 12; n++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_c", c, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (done || busy) seen = 1;
            @(negedge clk);
        end
        check("abort_no_done", 64'(seen), 64'd0);
        run_op(33'd2, 33'd3, res, lat, bc);
        check("after_abort_c", res, 64'd6);

        // Random operands, biased toward extreme values
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] x, y;
            x = WIDTH'({$urandom, $urandom});
            y = WIDTH'({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) x = {x[0], {(WIDTH-1){x[1]}}};
            if ($urandom_range(0, 3) == 0) y = WIDTH'($urandom_range(0, 7)) ^ {WIDTH{y[2]}};
            exp_c = model(x, y);
            run_op(x, y, res, lat, bc);
            check($sformatf("rand%0d_c", i), res, exp_c);
            check($sformatf("rand%0d_lat", i), 64'(lat_ok(lat)), 64'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
